// File: rtl/stream_quantizer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | stream_quantizer_if : input/output stream bundle of stream_quantizer   |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
interface stream_quantizer_if #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 16
);
  logic [IN_W-1:0]  in_data;
  logic [1:0]       in_mode;
  logic             in_valid;
  logic             in_ready;
  logic [OUT_W-1:0] out_data;
  logic             out_sat;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output in_data, in_mode, in_valid, out_ready,
    input  in_ready, out_data, out_sat, out_valid
  );

  modport slave (
    input  in_data, in_mode, in_valid, out_ready,
    output in_ready, out_data, out_sat, out_valid
  );
endinterface
`default_nettype wire

// File: rtl/stream_quantizer.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | stream_quantizer : 2-stage fixed-point requantizer (round, shift, sat) |
// | rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module stream_quantizer #(
  parameter int IN_W  = 32,
  parameter int IN_F  = 16,
  parameter int OUT_W = 16,
  parameter int OUT_F = 10
) (
  input  logic                clk,
  input  logic                rst,
  stream_quantizer_if.slave   bus,
  input  logic                sat_clr,
  output logic [15:0]         sat_count
);
  localparam int          D          = IN_F - OUT_F;
  localparam int          SW         = IN_W + 1;
  localparam logic [15:0] LFSR_SEED  = 16'hACE1;
  localparam logic [15:0] COUNT_MAX  = 16'hFFFF;

  logic             stall;
  logic             in_fire;
  logic             out_fire;

  logic             s1_valid_q, s1_valid_d;
  logic [SW-1:0]    s1_sum_q, s1_sum_d;
  logic             out_valid_q, out_valid_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic             out_sat_q, out_sat_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic [15:0]      sat_count_q, sat_count_d;

  logic [SW-1:0]    inc_round;
  logic [SW-1:0]    inc_stoch;
  logic [SW-1:0]    inc;
  logic [SW-1:0]    q;
  logic             pos_ovf;
  logic             neg_ovf;

  // With no fraction bits dropped there is nothing to round.
  generate
    if (D > 0) begin : g_inc_frac
      assign inc_round = SW'(1) << (D - 1);
      assign inc_stoch = {{(SW-D){1'b0}}, lfsr_q[D-1:0]};
    end else begin : g_inc_none
      assign inc_round = '0;
      assign inc_stoch = '0;
    end
  endgenerate

  assign stall    = out_valid_q && !bus.out_ready;
  assign in_fire  = bus.in_valid && !stall;
  assign out_fire = out_valid_q && bus.out_ready;

  assign q       = $signed(s1_sum_q) >>> D;
  assign pos_ovf = !q[SW-1] && (|q[SW-2:OUT_W-1]);
  assign neg_ovf =  q[SW-1] && !(&q[SW-2:OUT_W-1]);

  always_comb begin
    inc = '0;
    case (bus.in_mode)
      2'b01:   inc = inc_round;
      2'b10:   inc = inc_stoch;
      default: inc = '0;
    endcase
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_sum_d    = s1_sum_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_sat_d   = out_sat_q;
    lfsr_d      = lfsr_q;
    sat_count_d = sat_count_q;

    if (!stall) begin
      s1_valid_d  = bus.in_valid;
      if (bus.in_valid) begin
        s1_sum_d = {bus.in_data[IN_W-1], bus.in_data} + inc;
      end
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        if (pos_ovf) begin
          out_data_d = {1'b0, {(OUT_W-1){1'b1}}};
          out_sat_d  = 1'b1;
        end else if (neg_ovf) begin
          out_data_d = {1'b1, {(OUT_W-1){1'b0}}};
          out_sat_d  = 1'b1;
        end else begin
          out_data_d = q[OUT_W-1:0];
          out_sat_d  = 1'b0;
        end
      end
    end

    // The stochastic increment above uses the pre-advance LFSR value.
    if (in_fire) begin
      lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
    end

    if (sat_clr) begin
      sat_count_d = '0;
    end else if (out_fire && out_sat_q && (sat_count_q != COUNT_MAX)) begin
      sat_count_d = sat_count_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_sum_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
      lfsr_q      <= LFSR_SEED;
      sat_count_q <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_sum_q    <= s1_sum_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_sat_q   <= out_sat_d;
      lfsr_q      <= lfsr_d;
      sat_count_q <= sat_count_d;
    end
  end

  assign bus.in_ready  = !stall;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.out_valid = out_valid_q;
  assign sat_count     = sat_count_q;
endmodule
`default_nettype wire
